vx_perf_ctr_bank: RTL

Parametrised bank of event counters for the memory-system and pipeline performance path. It is the successor to the fixed-field memsys counter bundle. Each of NUM_CTRS channels accumulates a multi-bit per-cycle increment, with selectable wrap or saturate arithmetic and a sticky overflow flag per channel. A snapshot command atomically copies every live counter into a shadow bank, and the CSR/DCR side reads the shadow bank one counter at a time through a valid/ready request/response port.

---
 rtl/vx_perf_ctr_bank_if.sv | 31 +++
 rtl/vx_perf_ctr_bank.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/vx_perf_ctr_bank_if.sv
// ----------------------------------------------------------------------------
// vx_perf_ctr_bank_if
// Read port of the performance counter bank: one valid/ready request channel
// carrying a counter index and one valid/ready response channel carrying the
// shadow value, its sticky overflow flag and an address-range error flag.
//   master : request producer / response consumer (CSR/DCR side)
//   slave  : the counter bank
// ----------------------------------------------------------------------------
interface vx_perf_ctr_bank_if #(
   parameter int ADDRW    = 4,
   parameter int CTR_BITS = 44
);
   logic                rd_req_valid;
   logic [ADDRW-1:0]    rd_req_addr;
   logic                rd_req_ready;
   logic                rd_rsp_valid;
   logic [CTR_BITS-1:0] rd_rsp_data;
   logic                rd_rsp_ovf;
   logic                rd_rsp_err;
   logic                rd_rsp_ready;

   modport master (
      output rd_req_valid, rd_req_addr, rd_rsp_ready,
      input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_ovf, rd_rsp_err
   );

   modport slave (
      input  rd_req_valid, rd_req_addr, rd_rsp_ready,
      output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_ovf, rd_rsp_err
   );
endinterface

// File: rtl/vx_perf_ctr_bank.sv
// ----------------------------------------------------------------------------
// vx_perf_ctr_bank
// Bank of NUM_CTRS event counters. Each channel adds a per-cycle increment
// (wrap or saturate arithmetic) and keeps a sticky overflow flag. A snapshot
// pulse copies all live counters and flags into a shadow bank, which is read
// one entry at a time through a single-entry registered response port.
// Ports:
//   clk_i        clock, all state on rising edge
//   reset_i      asynchronous active-high reset
//   enable_i     global count enable
//   inc_i        per-channel increments, channel i at [i*INC_BITS +: INC_BITS]
//   clear_i      zero live counters and flags (increments of that cycle lost)
//   snapshot_i   copy live bank into shadow bank
//   snap_done_o  one-cycle pulse after a snapshot edge
//   ovf_any_o    OR of all live overflow flags
//   rd           shadow-bank read port (slave side)
// ----------------------------------------------------------------------------
module vx_perf_ctr_bank #(
   parameter int NUM_CTRS = 16,
   parameter int CTR_BITS = 44,
   parameter int INC_BITS = 4,
   parameter int SATURATE = 0,
   parameter int ADDRW    = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         enable_i,
   input  logic [NUM_CTRS*INC_BITS-1:0] inc_i,
   input  logic                         clear_i,
   input  logic                         snapshot_i,
   output logic                         snap_done_o,
   output logic                         ovf_any_o,
   vx_perf_ctr_bank_if.slave            rd
);

   localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};

   logic [CTR_BITS-1:0] cnt_q [NUM_CTRS];
   logic [CTR_BITS-1:0] cnt_d [NUM_CTRS];
   logic [NUM_CTRS-1:0] ovf_q;
   logic [NUM_CTRS-1:0] ovf_d;
   logic [CTR_BITS-1:0] shadow_q [NUM_CTRS];
   logic [NUM_CTRS-1:0] shadow_ovf_q;
   logic                snap_done_q;
   logic                ovf_any_q;
   logic                rsp_valid_q;
   logic [CTR_BITS-1:0] rsp_data_q;
   logic                rsp_ovf_q;
   logic                rsp_err_q;
   logic [CTR_BITS:0]   sum_s [NUM_CTRS];
   logic                req_fire_s;
   logic                addr_ok_s;

   // Live-bank next state: one extra sum bit exposes the carry-out.
   always_comb begin
      for (int i = 0; i < NUM_CTRS; i++) begin
         sum_s[i] = {1'b0, cnt_q[i]} + (CTR_BITS+1)'(inc_i[i*INC_BITS +: INC_BITS]);
         cnt_d[i] = cnt_q[i];
         ovf_d[i] = ovf_q[i];
         if (clear_i) begin
            cnt_d[i] = {CTR_BITS{1'b0}};
            ovf_d[i] = 1'b0;
         end else if (enable_i) begin
            if (sum_s[i][CTR_BITS]) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = (SATURATE != 0) ? CTR_MAX : sum_s[i][CTR_BITS-1:0];
            end else begin
               cnt_d[i] = sum_s[i][CTR_BITS-1:0];
            end
         end else begin
            cnt_d[i] = cnt_q[i];
         end
      end
   end

   // A new request may enter when the output register is empty or draining.
   assign rd.rd_req_ready = !rsp_valid_q || rd.rd_rsp_ready;
   assign req_fire_s      = rd.rd_req_valid && rd.rd_req_ready;
   assign addr_ok_s       = (int'(rd.rd_req_addr) < NUM_CTRS);

   // Live counters and sticky flags; ovf_any registers the OR of the next
   // flags so it equals the OR of the flag registers every cycle.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_CTRS; i++) begin
            cnt_q[i] <= {CTR_BITS{1'b0}};
         end
         ovf_q     <= {NUM_CTRS{1'b0}};
         ovf_any_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CTRS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         ovf_q     <= ovf_d;
         ovf_any_q <= |ovf_d;
      end
   end

   // Shadow bank captures the pre-update live registers, so a snapshot in a
   // clear cycle yields the pre-clear values (atomic read-and-reset).
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_CTRS; i++) begin
            shadow_q[i] <= {CTR_BITS{1'b0}};
         end
         shadow_ovf_q <= {NUM_CTRS{1'b0}};
         snap_done_q  <= 1'b0;
      end else begin
         if (snapshot_i) begin
            for (int i = 0; i < NUM_CTRS; i++) begin
               shadow_q[i] <= cnt_q[i];
            end
            shadow_ovf_q <= ovf_q;
         end else begin
            shadow_ovf_q <= shadow_ovf_q;
         end
         snap_done_q <= snapshot_i;
      end
   end

   // Response register: loaded on acceptance from the current (pre-snapshot)
   // shadow, held while the consumer stalls, emptied when it drains.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {CTR_BITS{1'b0}};
         rsp_ovf_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else if (req_fire_s) begin
         rsp_valid_q <= 1'b1;
         if (addr_ok_s) begin
            rsp_data_q <= shadow_q[rd.rd_req_addr];
            rsp_ovf_q  <= shadow_ovf_q[rd.rd_req_addr];
            rsp_err_q  <= 1'b0;
         end else begin
            rsp_data_q <= {CTR_BITS{1'b0}};
            rsp_ovf_q  <= 1'b0;
            rsp_err_q  <= 1'b1;
         end
      end else if (rd.rd_rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_q;
      end
   end

   assign rd.rd_rsp_valid = rsp_valid_q;
   assign rd.rd_rsp_data  = rsp_data_q;
   assign rd.rd_rsp_ovf   = rsp_ovf_q;
   assign rd.rd_rsp_err   = rsp_err_q;
   assign snap_done_o     = snap_done_q;
   assign ovf_any_o       = ovf_any_q;

endmodule
